// File: rtl/rename_alloc.sv
// Register-rename allocator: speculative (SRAT) and committed (CRAT) alias tables with free-list handshake.
// Optional macro RENAME_STALLCNT_EN enables the StallCnt input-stall counter.
module rename_alloc #(
  parameter int ARCHNUM  = 24,
  parameter int PREGWIDE = 5
) (
  input  logic                Clk,
  input  logic                Rest,
  input  logic                InValid,
  output logic                InReady,
  input  logic [4:0]          InRj,
  input  logic [4:0]          InRk,
  input  logic [4:0]          InRd,
  input  logic                InRdWen,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [PREGWIDE-1:0] OutPj,
  output logic [PREGWIDE-1:0] OutPk,
  output logic [PREGWIDE-1:0] OutPd,
  output logic [PREGWIDE-1:0] OutOldPd,
  output logic                OutRdWen,
  output logic                FlRable,
  input  logic [PREGWIDE-1:0] FlPreOut,
  input  logic                FlEmpty,
  output logic                FlWable,
  output logic [PREGWIDE-1:0] FlDin,
  input  logic                CmtValid,
  input  logic                CmtRdWen,
  input  logic [4:0]          CmtRd,
  input  logic [PREGWIDE-1:0] CmtPd,
  input  logic [PREGWIDE-1:0] CmtOldPd,
  input  logic                Flush,
  output logic [31:0]         StallCnt
);

  localparam logic [5:0] ARCH_LIM = 6'(ARCHNUM);

  logic [PREGWIDE-1:0] srat_q [ARCHNUM];
  logic [PREGWIDE-1:0] srat_d [ARCHNUM];
  logic [PREGWIDE-1:0] crat_q [ARCHNUM];
  logic [PREGWIDE-1:0] crat_d [ARCHNUM];
  logic                out_valid_q, out_valid_d;
  logic [PREGWIDE-1:0] out_pj_q, out_pj_d, out_pk_q, out_pk_d;
  logic [PREGWIDE-1:0] out_pd_q, out_pd_d, out_old_q, out_old_d;
  logic                out_wen_q, out_wen_d;
  logic                need_s, accept_s, cmt_ok_s, in_ready_s;

  function automatic logic renamed(input logic [4:0] idx);
    return (idx != 5'd0) && ({1'b0, idx} < ARCH_LIM);
  endfunction

  // Boot mapping: arch n takes the n-th nonzero tag that is not 2 mod 4.
  function automatic logic [PREGWIDE-1:0] reset_tag(input int arch);
    int                  seen;
    logic [PREGWIDE-1:0] tag;
    seen = 0;
    tag  = {PREGWIDE{1'b0}};
    for (int t = 1; t < (1 << PREGWIDE); t++) begin
      if ((t % 4) != 2) begin
        seen = seen + 1;
        if (seen == arch) tag = PREGWIDE'(t);
      end
    end
    return tag;
  endfunction

  assign need_s     = InRdWen && renamed(InRd);
  assign in_ready_s = Rest && (!out_valid_q || OutReady) && !(need_s && FlEmpty) && !Flush;
  assign accept_s   = InValid && in_ready_s;
  assign cmt_ok_s   = Rest && CmtValid && CmtRdWen && renamed(CmtRd);

  assign InReady  = in_ready_s;
  assign FlRable  = accept_s && need_s;
  assign FlWable  = cmt_ok_s;
  assign FlDin    = cmt_ok_s ? CmtOldPd : {PREGWIDE{1'b0}};
  assign OutValid = out_valid_q;
  assign OutPj    = out_pj_q;
  assign OutPk    = out_pk_q;
  assign OutPd    = out_pd_q;
  assign OutOldPd = out_old_q;
  assign OutRdWen = out_wen_q;

  // Next-state for alias tables and the output stage.
  always_comb begin
    srat_d      = srat_q;
    crat_d      = crat_q;
    out_valid_d = out_valid_q;
    out_pj_d    = out_pj_q;
    out_pk_d    = out_pk_q;
    out_pd_d    = out_pd_q;
    out_old_d   = out_old_q;
    out_wen_d   = out_wen_q;
    if (cmt_ok_s) begin
      crat_d[CmtRd] = CmtPd;
    end else begin
      crat_d = crat_q;
    end
    if (Flush) begin
      // Recover from committed state, including this cycle's retirement.
      srat_d = crat_q;
      if (cmt_ok_s) srat_d[CmtRd] = CmtPd;
      out_valid_d = 1'b0;
    end else if (accept_s) begin
      out_valid_d = 1'b1;
      out_pj_d    = renamed(InRj) ? srat_q[InRj] : {PREGWIDE{1'b0}};
      out_pk_d    = renamed(InRk) ? srat_q[InRk] : {PREGWIDE{1'b0}};
      out_pd_d    = need_s ? FlPreOut : {PREGWIDE{1'b0}};
      out_old_d   = need_s ? srat_q[InRd] : {PREGWIDE{1'b0}};
      out_wen_d   = need_s;
      if (need_s) srat_d[InRd] = FlPreOut;
    end else if (OutReady) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      for (int i = 0; i < ARCHNUM; i++) begin
        srat_q[i] <= reset_tag(i);
        crat_q[i] <= reset_tag(i);
      end
      out_valid_q <= 1'b0;
      out_pj_q    <= {PREGWIDE{1'b0}};
      out_pk_q    <= {PREGWIDE{1'b0}};
      out_pd_q    <= {PREGWIDE{1'b0}};
      out_old_q   <= {PREGWIDE{1'b0}};
      out_wen_q   <= 1'b0;
    end else begin
      srat_q      <= srat_d;
      crat_q      <= crat_d;
      out_valid_q <= out_valid_d;
      out_pj_q    <= out_pj_d;
      out_pk_q    <= out_pk_d;
      out_pd_q    <= out_pd_d;
      out_old_q   <= out_old_d;
      out_wen_q   <= out_wen_d;
    end
  end

`ifdef RENAME_STALLCNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where decode offers but is refused.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (InValid && !in_ready_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
`else
  assign StallCnt = 32'd0;
`endif

endmodule
